pc_state_regs: RTL and testbench
================================

# pc_state_regs

State-holding register bank for the MyISA processor's program-counter control path. It provides three storage elements:
- an enable-gated flag register (the `flopenr` behaviour);
- a start-gated program-counter register (the `flopr` behaviour);
- a sticky set-only flag.

All three share one clock and one asynchronous active-high reset. The next-PC and next-flag values are computed by combinational logic outside this block.

## Interface
Parameters:
- `FLAG_W`, default 2: width of the enable-gated flag register (ALU flags).
- `PC_W`, default 32: width of the start-gated PC register.
- `PC_RST`, default 0: PC value loaded on reset.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately, independent of `clk`.
- `start`  in  1  run enable for the PC register.
- `en`  in  1  load enable for the flag register.
- `d_flag`  in  FLAG_W  flag data input.
- `q_flag`  out  FLAG_W  registered flags.
- `d_pc`  in  PC_W  next-PC input.
- `q_pc`  out  PC_W  registered PC.
- `set_sticky`  in  1  sets the sticky flag.
- `sticky`  out  1  sticky flag (COM indication).

## Operation
- Flag register:
  - on a rising edge with `en`=1, `q_flag` <= `d_flag`;
  - with `en`=0, holds its value.
- PC register:
  - on a rising edge with `start`=1, `q_pc` <= `d_pc`;
  - with `start`=0, holds its value (processor stalled before launch).
- Sticky flag:
  - on a rising edge with `set_sticky`=1, `sticky` <= 1;
  - otherwise holds;
  - only `reset` (or `sclr` when configured) returns it to 0.
- The three elements are independent: any combination of `en`, `start` and `set_sticky` may be active in the same cycle, and each updates per its own rule.
- No arithmetic is performed. Widths pass through unchanged. `d_pc` is taken verbatim; PC wrap (for example 0xFFFFFFFC+4) is the external adder's concern.

## Timing
- Reset values while `reset`=1:
  - `q_flag`=0;
  - `q_pc`=`PC_RST`;
  - `sticky`=0.
- Reset asserts asynchronously: outputs change without waiting for a clock edge.
- Reset release is sampled on clock edges. The first edge with `reset`=0 may load data if the relevant enable is 1.
- Reset dominates every enable, including `reset` asserted mid-operation with `en`/`start` high.
- Load latency is 1 cycle: data present at edge N appears on the output after edge N. Outputs are registered and have no combinational path from any input.
- Enables are level-sensitive and are sampled only at rising edges. Glitches between edges have no effect.

## Configuration
- Macro: `PC_STATE_REGS_SCLR_EN`.
- Defined:
  - an extra port `sclr`, in, width 1, is present;
  - on a rising edge with `sclr`=1, all three elements load their reset values;
  - `sclr` has priority over `en`, `start` and `set_sticky`;
  - `reset` still dominates `sclr`.
- Not defined: no `sclr` port exists, and only `reset` clears state.

## Test plan
- Reset: drive nonzero `d_flag`/`d_pc` with `en`=`start`=`set_sticky`=1, assert `reset` between clock edges. Required: `q_flag`=0, `q_pc`=0, `sticky`=0 immediately, before the next edge.
- Flag enable: `d_flag`=2'b11, `en`=0 for 2 edges, then `en`=1 for 1 edge. Required: `q_flag` stays 2'b00 until after the enabled edge, then reads 2'b11; it then holds 2'b11 when `d_flag`=2'b01 with `en`=0.
- Start gating: `start`=0, `d_pc`=0x4 for 3 edges. Required: `q_pc`=0. Then `start`=1 with `d_pc` stepping 0x4, 0x8, 0xC on successive edges. Required: `q_pc` follows with 1-cycle latency.
- Sticky: pulse `set_sticky` for one cycle. Required: `sticky`=1 on that edge and remains 1 for 10 further cycles with `set_sticky`=0; it clears only on `reset`.
- Simultaneous events: `en`=1, `start`=1, `set_sticky`=1 in one cycle with `d_flag`=2'b10, `d_pc`=0x100. Required: after the edge, `q_flag`=2'b10, `q_pc`=0x100, `sticky`=1.
- With `PC_STATE_REGS_SCLR_EN` defined: `sclr`=1 and `start`=1 with `d_pc`=0x20 at the same edge. Required: `q_pc`=`PC_RST`, `q_flag`=0, `sticky`=0.

Source files
------------

// File: rtl/pc_state_regs.sv
// pc_state_regs: state-holding register bank for the MyISA PC control path.
//
// Holds three independent storage elements on one clock and one
// asynchronous active-high reset:
//   - q_flag : enable-gated flag register (loads d_flag when en=1)
//   - q_pc   : start-gated PC register (loads d_pc when start=1)
//   - sticky : set-only flag (set by set_sticky, cleared only by reset/sclr)
//
// Ports:
//   clk         in   1       rising-edge clock
//   reset       in   1       asynchronous, active-high clear
//   start       in   1       run enable for the PC register
//   en          in   1       load enable for the flag register
//   d_flag      in   FLAG_W  flag data input
//   q_flag      out  FLAG_W  registered flags
//   d_pc        in   PC_W    next-PC input (taken verbatim)
//   q_pc        out  PC_W    registered PC
//   set_sticky  in   1       sets the sticky flag
//   sticky      out  1       sticky flag (COM indication)
//   sclr        in   1       synchronous clear, present only when the
//                            macro PC_STATE_REGS_SCLR_EN is defined
//
// Configuration macro: PC_STATE_REGS_SCLR_EN
//   Defined   -> adds the sclr port; sclr=1 at a rising edge loads reset
//                values into all three elements, overriding en/start/
//                set_sticky. The asynchronous reset still dominates sclr.
//   Undefined -> no sclr port; only reset clears state.

module pc_state_regs #(
  parameter int unsigned          FLAG_W = 2,
  parameter int unsigned          PC_W   = 32,
  parameter logic [PC_W-1:0]      PC_RST = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              en,
  input  logic [FLAG_W-1:0] d_flag,
  output logic [FLAG_W-1:0] q_flag,
  input  logic [PC_W-1:0]   d_pc,
  output logic [PC_W-1:0]   q_pc,
  input  logic              set_sticky,
`ifdef PC_STATE_REGS_SCLR_EN
  input  logic              sclr,
`endif
  output logic              sticky
);

  // Synchronous clear qualifier; tied low when the feature is compiled out
  // so the register processes below are identical in both builds.
  logic clr;
`ifdef PC_STATE_REGS_SCLR_EN
  assign clr = sclr;
`else
  assign clr = 1'b0;
`endif

  // Flag register: enable-gated load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_flag <= '0;
    end else if (clr) begin
      q_flag <= '0;
    end else if (en) begin
      q_flag <= d_flag;
    end
  end

  // PC register: holds while the processor is stalled before launch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_pc <= PC_RST;
    end else if (clr) begin
      q_pc <= PC_RST;
    end else if (start) begin
      q_pc <= d_pc;
    end
  end

  // Sticky flag: set-only; nothing but a clear returns it to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky <= 1'b0;
    end else if (clr) begin
      sticky <= 1'b0;
    end else if (set_sticky) begin
      sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_state_regs.sv
module tb_pc_state_regs;

  localparam int unsigned FLAG_W = 2;
  localparam int unsigned PC_W   = 32;
  localparam logic [PC_W-1:0] PC_RST = '0;

  logic              clk;
  logic              reset;
  logic              start;
  logic              en;
  logic [FLAG_W-1:0] d_flag;
  logic [FLAG_W-1:0] q_flag;
  logic [PC_W-1:0]   d_pc;
  logic [PC_W-1:0]   q_pc;
  logic              set_sticky;
  logic              sticky;
  logic              sclr;

  int checks   = 0;
  int failures = 0;

  pc_state_regs #(
    .FLAG_W (FLAG_W),
    .PC_W   (PC_W),
    .PC_RST (PC_RST)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .en         (en),
    .d_flag     (d_flag),
    .q_flag     (q_flag),
    .d_pc       (d_pc),
    .q_pc       (q_pc),
    .set_sticky (set_sticky),
`ifdef PC_STATE_REGS_SCLR_EN
    .sclr       (sclr),
`endif
    .sticky     (sticky)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each element's value is the last input accepted at a
  // rising edge whose enable was high, since the most recent clear.
  logic [FLAG_W-1:0] m_flag   = '0;
  logic [PC_W-1:0]   m_pc     = PC_RST;
  logic              m_sticky = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_flag = '0; m_pc = PC_RST; m_sticky = 1'b0;
      end else begin
        bit clear_now;
`ifdef PC_STATE_REGS_SCLR_EN
        clear_now = sclr;
`else
        clear_now = 1'b0;
`endif
        if (clear_now) begin
          m_flag = '0; m_pc = PC_RST; m_sticky = 1'b0;
        end else begin
          if (en)         m_flag   = d_flag;
          if (start)      m_pc     = d_pc;
          if (set_sticky) m_sticky = 1'b1;
        end
      end
      #2;
      check("model_q_flag", 64'(q_flag), 64'(m_flag));
      check("model_q_pc",   64'(q_pc),   64'(m_pc));
      check("model_sticky", 64'(sticky), 64'(m_sticky));
    end
  end

  // Advance one edge; inputs are then changed well away from the edge.
  task automatic tick();
    @(posedge clk);
    #4;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; en = 1'b0; set_sticky = 1'b0;
    d_flag = '0; d_pc = '0; sclr = 1'b0;
    tick(); tick();
    check("reset_q_flag", 64'(q_flag), 64'h0);
    check("reset_q_pc",   64'(q_pc),   64'h0);
    check("reset_sticky", 64'(sticky), 64'h0);

    // First edge after release loads everything.
    reset = 1'b0; en = 1'b1; start = 1'b1; set_sticky = 1'b1;
    d_flag = 2'b11; d_pc = 32'h55;
    tick();
    check("load_q_flag", 64'(q_flag), 64'h3);
    check("load_q_pc",   64'(q_pc),   64'h55);
    check("load_sticky", 64'(sticky), 64'h1);

    // Asynchronous reset between edges with all enables high.
    d_flag = 2'b10; d_pc = 32'hABC;
    reset = 1'b1;
    #1;
    check("async_q_flag", 64'(q_flag), 64'h0);
    check("async_q_pc",   64'(q_pc),   64'h0);
    check("async_sticky", 64'(sticky), 64'h0);
    tick();
    check("rst_dom_q_pc", 64'(q_pc), 64'h0);
    reset = 1'b0; en = 1'b0; start = 1'b0; set_sticky = 1'b0;

    // Flag enable.
    d_flag = 2'b11;
    tick(); tick();
    check("flag_hold0", 64'(q_flag), 64'h0);
    en = 1'b1;
    tick();
    check("flag_load", 64'(q_flag), 64'h3);
    en = 1'b0; d_flag = 2'b01;
    tick();
    check("flag_hold3", 64'(q_flag), 64'h3);

    // Start gating.
    d_pc = 32'h4;
    tick(); tick(); tick();
    check("pc_stalled", 64'(q_pc), 64'h0);
    start = 1'b1;
    tick(); check("pc_step4", 64'(q_pc), 64'h4);
    d_pc = 32'h8;
    tick(); check("pc_step8", 64'(q_pc), 64'h8);
    d_pc = 32'hC;
    tick(); check("pc_stepC", 64'(q_pc), 64'hC);
    d_pc = 32'hFFFF_FFFC;
    tick(); check("pc_verbatim", 64'(q_pc), 64'hFFFF_FFFC);
    start = 1'b0;

    // Sticky: one-cycle pulse, then holds for 10 cycles.
    check("sticky_pre", 64'(sticky), 64'h0);
    set_sticky = 1'b1;
    tick(); check("sticky_set", 64'(sticky), 64'h1);
    set_sticky = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("sticky_hold", 64'(sticky), 64'h1);
    #1 reset = 1'b1;
    #1 check("sticky_clr", 64'(sticky), 64'h0);
    tick();
    reset = 1'b0;

    // Simultaneous events.
    en = 1'b1; start = 1'b1; set_sticky = 1'b1;
    d_flag = 2'b10; d_pc = 32'h100;
    tick();
    check("simul_q_flag", 64'(q_flag), 64'h2);
    check("simul_q_pc",   64'(q_pc),   64'h100);
    check("simul_sticky", 64'(sticky), 64'h1);

    // Mixed vectors checked by the model only.
    for (int i = 0; i < 20; i++) begin
      en = 1'($urandom_range(1)); start = 1'($urandom_range(1));
      set_sticky = ($urandom_range(7) == 0);
      d_flag = FLAG_W'($urandom); d_pc = $urandom;
      tick();
    end

`ifdef PC_STATE_REGS_SCLR_EN
    en = 1'b1; start = 1'b1; set_sticky = 1'b1;
    d_flag = 2'b01; d_pc = 32'h40;
    tick();
    sclr = 1'b1; d_pc = 32'h20; d_flag = 2'b11;
    tick();
    check("sclr_q_pc",   64'(q_pc),   64'(PC_RST));
    check("sclr_q_flag", 64'(q_flag), 64'h0);
    check("sclr_sticky", 64'(sticky), 64'h0);
    sclr = 1'b0;
    tick();
    check("after_sclr_q_pc", 64'(q_pc), 64'h20);
`endif

    en = 1'b0; start = 1'b0; set_sticky = 1'b0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
